// File: rtl/mmu_seq_ctrl.sv
// Phase controller for the systolic MMU array: weight load, input feed and drain,
// with a delay line that turns feed strobes into result-buffer write strobes.
module mmu_seq_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int ROW_NUM    = 8,
  localparam int LAT = 2 * ARRAY_SIZE - 1,
  localparam int WW  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
  localparam int RW  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          stall_i,
  output logic          busy_o,
  output logic          w_load_o,
  output logic [WW-1:0] w_idx_o,
  output logic          feed_en_o,
  output logic [RW-1:0] in_addr_o,
  output logic          out_valid_o,
  output logic [RW-1:0] out_addr_o,
  output logic          done_o
);

  localparam logic [WW-1:0] W_LAST = WW'(ARRAY_SIZE - 1);
  localparam logic [WW-1:0] W_ONE  = WW'(1);
  localparam logic [RW-1:0] R_LAST = RW'(ROW_NUM - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [RW-1:0]  icnt_q, icnt_d;
  logic [RW-1:0]  ocnt_q, ocnt_d;
  logic [LAT-1:0] dly_q, dly_d;
  logic           hold;
  logic           ovalid;

  // Stall only freezes the three working phases; IDLE and DONE ignore it.
  assign hold   = stall_i && ((state_q == WLOAD) || (state_q == FEED) || (state_q == DRAIN));
  assign ovalid = dly_q[LAT-1] && !hold;

  // State, counters and delay line registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= {WW{1'b0}};
      icnt_q  <= {RW{1'b0}};
      ocnt_q  <= {RW{1'b0}};
      dly_q   <= {LAT{1'b0}};
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
      ocnt_q  <= ocnt_d;
      dly_q   <= dly_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = WLOAD;
        else         state_d = IDLE;
      end
      WLOAD: begin
        if (!stall_i && (wcnt_q == W_LAST)) state_d = FEED;
        else                                state_d = WLOAD;
      end
      FEED: begin
        if (!stall_i && (icnt_q == R_LAST)) state_d = DRAIN;
        else                                state_d = FEED;
      end
      DRAIN: begin
        if (ovalid && (ocnt_q == R_LAST)) state_d = DONE;
        else                              state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and delay-line next values.
  always_comb begin
    wcnt_d = {WW{1'b0}};
    icnt_d = {RW{1'b0}};
    ocnt_d = ocnt_q;
    dly_d  = dly_q;
    if (state_q == WLOAD) begin
      if (stall_i)                 wcnt_d = wcnt_q;
      else if (wcnt_q == W_LAST)   wcnt_d = {WW{1'b0}};
      else                         wcnt_d = wcnt_q + W_ONE;
    end else begin
      wcnt_d = {WW{1'b0}};
    end
    if (state_q == FEED) begin
      if (stall_i)                 icnt_d = icnt_q;
      else if (icnt_q == R_LAST)   icnt_d = {RW{1'b0}};
      else                         icnt_d = icnt_q + R_ONE;
    end else begin
      icnt_d = {RW{1'b0}};
    end
    if (state_q == IDLE)           ocnt_d = {RW{1'b0}};
    else if (ovalid) begin
      if (ocnt_q == R_LAST)        ocnt_d = {RW{1'b0}};
      else                         ocnt_d = ocnt_q + R_ONE;
    end else begin
      ocnt_d = ocnt_q;
    end
    if (hold) begin
      dly_d = dly_q;
    end else begin
      dly_d[0] = feed_en_o;
      for (int i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
    end
  end

  // Output decode.
  always_comb begin
    busy_o      = 1'b1;
    w_load_o    = 1'b0;
    w_idx_o     = {WW{1'b0}};
    feed_en_o   = 1'b0;
    in_addr_o   = {RW{1'b0}};
    out_valid_o = 1'b0;
    out_addr_o  = ocnt_q;
    done_o      = 1'b0;
    case (state_q)
      IDLE: busy_o = 1'b0;
      WLOAD: begin
        w_load_o = !stall_i;
        w_idx_o  = wcnt_q;
      end
      FEED: begin
        feed_en_o   = !stall_i;
        in_addr_o   = icnt_q;
        out_valid_o = ovalid;
      end
      DRAIN: out_valid_o = ovalid;
      DONE:  done_o = 1'b1;
      default: begin
        busy_o     = 1'b0;
        out_addr_o = {RW{1'b0}};
      end
    endcase
  end

endmodule
